// File: rtl/cla_subtractor_seq.sv
// cla_subtractor_seq: nibble-serial lookahead-borrow subtractor with valid/ready handshakes.
// Define SUB_OVERFLOW_EN to add the signed overflow output.
module cla_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    localparam int NS = WIDTH / 4;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
        $error("WIDTH must be a positive multiple of 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             borrow_q, borrow_d, bout_q, bout_d;
    logic [3:0]       a_s, nb_s, p, g;
    logic [4:0]       c;
    logic             last;
`ifdef SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    // Subtraction as a + ~b + ~borrow: carry-in of each slice is the inverted borrow.
    always_comb begin
        a_s  = '0;
        nb_s = '0;
        for (int k = 0; k < NS; k++) begin
            if (idx_q == IW'(k)) begin
                a_s  = a_q[4*k +: 4];
                nb_s = ~b_q[4*k +: 4];
            end
        end
        p    = a_s ^ nb_s;
        g    = a_s & nb_s;
        c[0] = ~borrow_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        last = idx_q == IW'(NS - 1);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NS; k++)
                    if (idx_q == IW'(k)) diff_d[4*k +: 4] = p ^ c[3:0];
                borrow_d = ~c[4];
                idx_d    = last ? '0 : idx_q + 1'b1;
                if (last) begin
                    bout_d  = ~c[4];
                    state_d = DONE;
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_subtractor_seq.sv
// tb_cla_subtractor_seq: directed and random checks of cla_subtractor_seq against an arithmetic model.
module tb_cla_subtractor_seq;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         bin_r = 1'b0;
    logic [W-1:0] a_r = '0;
    logic [W-1:0] b_r = '0;
    logic         in_ready, out_valid, bout;
    logic [W-1:0] diff;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 computing, 2 result presented.
    int           m_ph = 0;
    int           m_cnt = 0;
    bit           m_fresh = 1'b1;
    logic [W:0]   m_res = '0;
    logic         m_ovf = 1'b0;

    always #5 clk = ~clk;

    cla_subtractor_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_r), .b(b_r), .bin(bin_r), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
`ifdef SUB_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph    = 0;
            m_fresh = 1'b1;
        end else if (m_ph == 0) begin
            if (in_valid) begin
                m_res   = {1'b0, a_r} - {1'b0, b_r} - {{W{1'b0}}, bin_r};
                m_ovf   = (a_r[W-1] != b_r[W-1]) && (m_res[W-1] != a_r[W-1]);
                m_cnt   = NS;
                m_ph    = 1;
                m_fresh = 1'b0;
            end
        end else if (m_ph == 1) begin
            m_cnt--;
            if (m_cnt == 0) m_ph = 2;
        end else if (out_ready) begin
            m_ph = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_ph == 0);
        chk("out_valid", out_valid, m_ph == 2);
        if (m_ph == 2) begin
            chk("result", {bout, diff}, m_res);
`ifdef SUB_OVERFLOW_EN
            chk("overflow", overflow, m_ovf);
`endif
        end
        if (m_ph == 0 && m_fresh) chk("reset_result", {bout, diff}, 0);
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      input logic [W-1:0] ediff, input logic ebout, input logic eovf,
                      input int hold, input bit poke);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("idle_wait", in_ready, 1);
        a_r = ta; b_r = tb; bin_r = tbin; in_valid = 1'b1; out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        if (poke) begin
            in_valid = 1'b1; a_r = ~ta; b_r = ta; bin_r = ~tbin;
        end
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("latency", n, NS);
        chk("lit_diff", diff, ediff);
        chk("lit_bout", bout, ebout);
`ifdef SUB_OVERFLOW_EN
        chk("lit_overflow", overflow, eovf);
`else
        if (eovf === 1'bx) chk("eovf_known", eovf, 0);
`endif
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_diff", diff, ediff);
            chk("hold_bout", bout, ebout);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("released", out_valid, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        #2 rst_n = 1'b1;

        op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 0);
        op(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 0, 0);
        op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 0);
        op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 0);
        op(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 3, 1);

        // Abort an operation two cycles into RUN.
        @(negedge clk);
        a_r = 16'h4321; b_r = 16'h1111; bin_r = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_valid", out_valid, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0, 0);

        op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0, 0);
        op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1, 0);
        op(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            int n;
            bit r;
            n = 0;
            while (!in_ready && n < 50) begin @(negedge clk); n++; end
            a_r = W'($urandom); b_r = W'($urandom); bin_r = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 20) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            if (!out_valid) chk("rand_timeout", out_valid, 1);
            n = 0;
            do begin
                r = (n >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                out_ready = r;
                @(negedge clk);
                n++;
            end while (!r);
        end

        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
